mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multicycle MIPS main control FSM; initiator side of the ALU interface (drives alu_op,
//  operand selects). Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction from
//  IR opcode/funct and ALU zero flag. Sits between instruction register and datapath muxes/ALU.
// PARAMETERS
//  none. All encodings are fixed constants in mips_pkg.
// PORTS
//  clk          in   1  single clock; all state changes on rising edge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   6  IR[31:26], stable from DECODE until next FETCH
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag (out32 == 0)
//  pc_write     out  1  PC load enable (already includes the beq/zero term)
//  i_or_d       out  1  mem addr: 0=PC, 1=ALUOut
//  mem_read     out  1
//  mem_write    out  1
//  ir_write     out  1
//  mem_to_reg   out  1  0=ALUOut, 1=MDR
//  reg_dst      out  1  0=rt, 1=rd
//  reg_write    out  1
//  alu_src_a    out  1  0=PC, 1=regA
//  alu_src_b    out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
//  alu_op       out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLT, 0101 NOR
//  pc_source    out  2  00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op   out  1  one-cycle pulse on unsupported opcode/funct
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  - Moore outputs decoded from state; pc_write = PCWrite | (in BEQ & zero).
//  - rst high at rising edge -> state=FETCH. Any state, mid-instruction included, is
//    abandoned. While rst is high, all write enables (pc_write, ir_write, reg_write,
//    mem_write, mem_read) are forced 0, and illegal_op=0.
//  - FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD,
//    pc_source=00, pc_write=1 -> DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target to ALUOut).
//    Next state: lw/sw(100011/101011)->MEMADR; R(000000)->RTYPE_EX; beq(000100)->BEQ;
//    addi(001000)->ADDI_EX; j(000010)->JUMP; other->FETCH with illegal_op=1.
//  - MEMADR: src_a=1, src_b=10, ADD -> MEMRD (lw) | MEMWR (sw).
//  - MEMRD: mem_read=1, i_or_d=1 -> MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - MEMWR: mem_write=1, i_or_d=1 -> FETCH.
//  - RTYPE_EX: src_a=1, src_b=00, alu_op from funct: 100000 ADD, 100010 SUB, 100100 AND,
//    100101 OR, 101010 SLT, 100111 NOR -> RTYPE_WB. Unsupported funct: illegal_op=1,
//    alu_op=ADD, -> FETCH (no writeback).
//  - RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - BEQ: src_a=1, src_b=00, alu_op=SUB, pc_source=01, pc_write=zero -> FETCH.
//  - ADDI_EX: src_a=1, src_b=10, ADD -> ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0 -> FETCH.
//  - JUMP: pc_source=10, pc_write=1 -> FETCH.
//  - Defaults in every state: all enables 0, selects 0, alu_op=ADD.
//  - Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
//  - Unused state encodings -> FETCH on next edge, enables 0.
//  - Exactly one of mem_read/mem_write is high in any cycle, or neither.
// STRUCTURE
//  - mips_pkg: state localparams, opcode/funct constants, ALUop codes, alu_src_b and
//    pc_source codes (shared with the ALU and datapath).
//  - Sub-module mips_alu_decoder: combinational funct -> {alu_op, funct_ok}, instantiated
//    in RTYPE_EX output decode.
//  - Separate next-state register block and output decode block.
// TESTING
//  - rst=1 in MEMRD mid-lw -> next state FETCH, no reg_write, enables 0 while rst=1.
//  - lw (100011) from FETCH -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 only
//    in cycle 5, mem_to_reg=1.
//  - R-type funct 100010 -> alu_op=0011 in RTYPE_EX, reg_write=1/reg_dst=1 next cycle.
//    Repeat for all 6 funct values.
//  - beq with zero=1 -> pc_write=1, pc_source=01 in cycle 3; zero=0 -> pc_write=0.
//  - opcode 111111 -> illegal_op pulse in DECODE, FETCH next; funct 000000 -> pulse in
//    RTYPE_EX, no writeback.
//  - Back-to-back sw, j, addi -> 4/3/4 cycles; check mem_write and pc_write counts.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// constants, ALU operation codes and datapath mux select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic opcode_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct field to ALU operation; funct_ok flags the supported subset.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_ok
);

  always_comb begin
    alu_op   = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_NOR:  alu_op = ALU_NOR;
      default: funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: Moore outputs per state, with the beq zero term
// folded into pc_write and all write enables suppressed while rst is high.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t     state_q, state_d;
  logic [3:0] rtype_alu_op;
  logic       funct_ok;

  mips_alu_decoder u_alu_dec (
    .funct    (funct),
    .alu_op   (rtype_alu_op),
    .funct_ok (funct_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = funct_ok ? S_RTYPE_WB : S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    pc_source  = PCSRC_ALU;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMMSH;
        illegal_op = !opcode_known(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a  = 1'b1;
        alu_op     = funct_ok ? rtype_alu_op : ALU_ADD;
        illegal_op = !funct_ok;
      end
      S_RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = zero;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset takes effect combinationally so nothing is written in the abandoned cycle.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: per-cycle stimulus and expected output
// vectors are queued, the driver captures observed vectors, each test compares them.
module tb_mips_mc_control;
  import mips_pkg::*;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0011;
  localparam logic [3:0] A_SLT = 4'b0100;
  localparam logic [3:0] A_NOR = 4'b0101;

  logic       clk, rst, zero;
  logic [5:0] opcode, funct;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op, state_dbg;

  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];
  logic [13:0] in_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {state, pcw, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill}
  function automatic logic [21:0] ev(input logic [3:0] st, input logic pcw, iord, mr, mw,
                                     irw, m2r, rd, rw, sa, input logic [1:0] sb,
                                     input logic [3:0] aop, input logic [1:0] ps,
                                     input logic ill);
    return {st, pcw, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill};
  endfunction

  function automatic logic [21:0] e_fetch(input logic in_rst);
    if (in_rst) return ev(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, A_ADD, 2'b00, 0);
    return ev(S_FETCH, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_decode(input logic ill);
    return ev(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, A_ADD, 2'b00, ill);
  endfunction
  function automatic logic [21:0] e_memadr();
    return ev(S_MEMADR, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_memrd(input logic in_rst);
    return ev(S_MEMRD, 0, 1, !in_rst, 0, 0, 0, 0, 0, 0, 2'b00, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_memwb();
    return ev(S_MEMWB, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_memwr();
    return ev(S_MEMWR, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_rex(input logic [3:0] aop, input logic ill);
    return ev(S_RTYPE_EX, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, aop, 2'b00, ill);
  endfunction
  function automatic logic [21:0] e_rwb();
    return ev(S_RTYPE_WB, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_beq(input logic z);
    return ev(S_BEQ, z, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, A_SUB, 2'b01, 0);
  endfunction
  function automatic logic [21:0] e_addi_ex();
    return ev(S_ADDI_EX, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_addi_wb();
    return ev(S_ADDI_WB, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, A_ADD, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_jump();
    return ev(S_JUMP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, A_ADD, 2'b10, 0);
  endfunction

  // driver tasks
  task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [21:0] e);
    in_q.push_back({r, op, fn, z});
    exp_q.push_back(e);
  endtask

  // Applies queued inputs one cycle at a time, capturing outputs 1 ns after the negedge.
  task automatic drive_cycles();
    logic [13:0] s;
    while (in_q.size() > 0) begin
      s = in_q.pop_front();
      {rst, opcode, funct, zero} = s;
      #1;
      obs_q.push_back({state_dbg, pc_write, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, illegal_op});
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [21:0] e, o;
    int i;
    push(1, OP_LW, 6'd0, 0, e_fetch(1));
    push(0, OP_LW, 6'd0, 0, e_fetch(0));
    push(0, OP_LW, 6'd0, 0, e_decode(0));
    push(0, OP_LW, 6'd0, 0, e_memadr());
    push(1, OP_LW, 6'd0, 0, e_memrd(1));
    push(1, OP_LW, 6'd0, 0, e_fetch(1));
    push(0, OP_LW, 6'd0, 0, e_fetch(0));
    push(0, OP_LW, 6'd0, 0, e_decode(0));
    push(0, OP_LW, 6'd0, 0, e_memadr());
    push(0, OP_LW, 6'd0, 0, e_memrd(0));
    push(0, OP_LW, 6'd0, 0, e_memwb());
    drive_cycles();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_lw cycle %0d: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn_t[6];
    logic [3:0] op_t[6];
    logic [21:0] e, o;
    int i;
    fn_t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    op_t = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT, A_NOR};
    for (int k = 0; k < 6; k++) begin
      push(0, OP_RTYPE, fn_t[k], 1'($urandom_range(0, 1)), e_fetch(0));
      push(0, OP_RTYPE, fn_t[k], 1'($urandom_range(0, 1)), e_decode(0));
      push(0, OP_RTYPE, fn_t[k], 1'($urandom_range(0, 1)), e_rex(op_t[k], 0));
      push(0, OP_RTYPE, fn_t[k], 1'($urandom_range(0, 1)), e_rwb());
    end
    drive_cycles();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rtype cycle %0d: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_beq();
    logic [21:0] e, o;
    int i;
    push(0, OP_BEQ, 6'd0, 1, e_fetch(0));
    push(0, OP_BEQ, 6'd0, 1, e_decode(0));
    push(0, OP_BEQ, 6'd0, 1, e_beq(1));
    push(0, OP_BEQ, 6'd0, 0, e_fetch(0));
    push(0, OP_BEQ, 6'd0, 0, e_decode(0));
    push(0, OP_BEQ, 6'd0, 0, e_beq(0));
    drive_cycles();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL beq cycle %0d: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_illegal();
    logic [21:0] e, o;
    int i;
    push(0, 6'b111111, 6'd0, 0, e_fetch(0));
    push(0, 6'b111111, 6'd0, 0, e_decode(1));
    push(0, OP_RTYPE, 6'b000000, 0, e_fetch(0));
    push(0, OP_RTYPE, 6'b000000, 0, e_decode(0));
    push(0, OP_RTYPE, 6'b000000, 0, e_rex(A_ADD, 1));
    push(0, OP_LW, 6'b000000, 0, e_fetch(0));
    drive_cycles();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL illegal cycle %0d: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e, o;
    int i, n_mw, n_pcw;
    // the lw left in DECODE by test_illegal is finished first
    push(0, OP_LW, 6'd0, 0, e_decode(0));
    push(0, OP_LW, 6'd0, 0, e_memadr());
    push(0, OP_LW, 6'd0, 0, e_memrd(0));
    push(0, OP_LW, 6'd0, 0, e_memwb());
    drive_cycles();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL lw_tail: got %h expected %h", o, e);
      end
    end
    push(0, OP_SW, 6'd0, 0, e_fetch(0));
    push(0, OP_SW, 6'd0, 0, e_decode(0));
    push(0, OP_SW, 6'd0, 0, e_memadr());
    push(0, OP_SW, 6'd0, 0, e_memwr());
    push(0, OP_J, 6'd0, 0, e_fetch(0));
    push(0, OP_J, 6'd0, 0, e_decode(0));
    push(0, OP_J, 6'd0, 0, e_jump());
    push(0, OP_ADDI, 6'd0, 0, e_fetch(0));
    push(0, OP_ADDI, 6'd0, 0, e_decode(0));
    push(0, OP_ADDI, 6'd0, 0, e_addi_ex());
    push(0, OP_ADDI, 6'd0, 0, e_addi_wb());
    drive_cycles();
    i = 0; n_mw = 0; n_pcw = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      n_mw  += int'(o[14]);
      n_pcw += int'(o[17]);
      if (o !== e) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, o, e);
      end
      i++;
    end
    n_cmp++;
    if (n_mw !== 1) begin
      n_bad++;
      $display("FAIL b2b_mem_write_count: got %0d expected 1", n_mw);
    end
    n_cmp++;
    if (n_pcw !== 4) begin
      n_bad++;
      $display("FAIL b2b_pc_write_count: got %0d expected 4", n_pcw);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_rtype();
    test_beq();
    test_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
